// File: rtl/md_defs.sv
// Shared op codes and decode helpers for the HI/LO multiply/divide unit.
package md_defs;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } md_op_e;

   // True for ops that occupy the unit for a counted busy period.
   function automatic logic is_multicycle(input logic [3:0] op);
      logic r;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_divide(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result datapath: next HI/LO from the latched op and operands.
module md_arith
   import md_defs::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi_cur,
   input  logic [WIDTH-1:0] lo_cur,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next,
   output logic             div_zero
);

   logic [2*WIDTH-1:0] acc, prod_s, prod_u;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   dividend, divisor, q_mag, r_mag, quotient, remainder;

   assign acc    = {hi_cur, lo_cur};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   // Sign-extend to full width; the low 2*WIDTH bits of the product are exact.
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

   // Signed divide runs on magnitudes; -MIN as unsigned is the correct magnitude.
   assign div_zero  = is_divide(op) && (b == '0);
   assign neg_a     = (op == OP_DIV) && a[WIDTH-1];
   assign neg_b     = (op == OP_DIV) && b[WIDTH-1];
   assign dividend  = neg_a ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
   // Substitute 1 for a zero divisor so the divider never sees x/0.
   assign divisor   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} :
                      neg_b ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
   assign q_mag     = dividend / divisor;
   assign r_mag     = dividend % divisor;
   assign quotient  = (neg_a ^ neg_b) ? (~q_mag + {{(WIDTH-1){1'b0}}, 1'b1}) : q_mag;
   assign remainder = neg_a ? (~r_mag + {{(WIDTH-1){1'b0}}, 1'b1}) : r_mag;

   // Select the result for the latched op; anything else leaves HI/LO as they are.
   always_comb begin
      hi_next = hi_cur;
      lo_next = lo_cur;
      case (op)
         OP_MULT:  {hi_next, lo_next} = prod_s;
         OP_MULTU: {hi_next, lo_next} = prod_u;
         OP_MADD:  {hi_next, lo_next} = acc + prod_s;
         OP_MADDU: {hi_next, lo_next} = acc + prod_u;
         OP_MSUB:  {hi_next, lo_next} = acc - prod_s;
         OP_MSUBU: {hi_next, lo_next} = acc - prod_u;
         OP_DIV, OP_DIVU: begin
            if (b != '0) begin
               lo_next = quotient;
               hi_next = remainder;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: accept/cancel control, busy counter and HI/LO state.
module mult_div_unit
   import md_defs::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             md_stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] arith_hi, arith_lo;
   logic             arith_div_zero;
   logic             accept;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .hi_cur   (hi_q),
      .lo_cur   (lo_q),
      .hi_next  (arith_hi),
      .lo_next  (arith_lo),
      .div_zero (arith_div_zero)
   );

   assign busy     = (cnt_q != '0);
   // A flushed instruction must never issue, so cancel also blocks accept.
   assign accept   = start & ~busy & ~cancel;
   assign md_stall = busy | (start & is_multicycle(md_op));
   assign hi       = hi_q;
   assign lo       = lo_q;

   // Next state: count down / commit / cancel while busy, otherwise accept new ops.
   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (busy) begin
         if (cancel) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && !arith_div_zero) begin
               hi_d = arith_hi;
               lo_d = arith_lo;
            end
         end
      end else if (accept) begin
         if (is_multicycle(md_op)) begin
            op_d  = md_op;
            a_d   = src_a;
            b_d   = src_b;
            cnt_d = is_divide(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (md_op == OP_MTHI) begin
            hi_d = src_a;
         end else if (md_op == OP_MTLO) begin
            lo_d = src_a;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

endmodule
